// File: rtl/hash_receiver_pkg.sv
// -----------------------------------------------------------------------------
// hash_receiver_pkg
// Shared constants for the hash receive path and the downstream comparator:
// frame length, frame delimiter and the receive FSM state encoding.
// -----------------------------------------------------------------------------
package hash_receiver_pkg;

    // Number of hash bytes in one frame.
    localparam int HASH_NUM_BYTES = 16;

    // Byte that terminates a frame.
    localparam logic [7:0] HASH_DELIM = 8'h2C;

    // Receive FSM state encoding. The comparator decodes these values too,
    // so they are kept as fixed constants rather than a tool-chosen enum.
    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    // True when a received byte is the frame delimiter.
    function automatic logic is_delim(input logic [7:0] data, input logic [7:0] delim);
        return data == delim;
    endfunction

endpackage

// File: rtl/hash_receiver_rx_ack_ctrl.sv
// -----------------------------------------------------------------------------
// rx_ack_ctrl
// Four-phase handshake with the UART receiver. A byte is taken when Rx_Ready
// is high, Rx_Ack is low and the consumer is willing (take_enable). Rx_Ack is
// raised on the following cycle and held until Rx_Ready is seen low; that
// release completes regardless of take_enable.
//
// Ports
//   Clk         : clock
//   Reset       : active-low reset (already synchronised on deassertion)
//   rx_ready    : UART byte-available level
//   take_enable : consumer can accept a byte this cycle
//   rx_ack      : acknowledge back to the UART
//   byte_take   : one-cycle strobe, byte on Rx_Data is consumed this cycle
// -----------------------------------------------------------------------------
module rx_ack_ctrl (
    input  logic Clk,
    input  logic Reset,
    input  logic rx_ready,
    input  logic take_enable,
    output logic rx_ack,
    output logic byte_take
);

    logic ack_reg;
    logic ack_next;

    // Rx_Ack is high in the cycle after a take, so the strobe cannot last
    // more than one cycle.
    assign byte_take = rx_ready && !ack_reg && take_enable;

    always_comb begin
        ack_next = ack_reg;
        if (byte_take) begin
            ack_next = 1'b1;
        end else if (ack_reg && !rx_ready) begin
            ack_next = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ack_reg <= 1'b0;
        end else begin
            ack_reg <= ack_next;
        end
    end

    assign rx_ack = ack_reg;

endmodule

// File: rtl/hash_receiver.sv
// -----------------------------------------------------------------------------
// hash_receiver
// Assembles NUM_BYTES hash bytes received from a UART into one wide word,
// terminated by DELIM. A complete frame is held on Hash_Value with Hash_Valid
// high until the comparator accepts it with Hash_Ready; while held, no new
// byte is consumed, which backpressures the UART. Malformed frames (too short
// or too long) give a one-cycle Frame_Error pulse; an over-long frame is
// dropped up to and including its delimiter.
//
// Ports
//   Clk         : clock
//   Reset       : asynchronous active-low reset
//   Rx_Data     : received byte, valid while Rx_Ready is high
//   Rx_Ready    : UART byte-available level
//   Rx_Ack      : byte-consumed acknowledge to the UART
//   Hash_Value  : assembled hash, first received byte in the top byte
//   Hash_Valid  : Hash_Value holds a complete frame
//   Hash_Ready  : comparator accepts Hash_Value
//   Frame_Error : one-cycle pulse on a malformed frame
//   Byte_Count  : hash bytes collected in the current frame
// -----------------------------------------------------------------------------
module hash_receiver
    import hash_receiver_pkg::*;
#(
    parameter int         NUM_BYTES = HASH_NUM_BYTES,
    parameter logic [7:0] DELIM     = HASH_DELIM
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [7:0]             Rx_Data,
    input  logic                   Rx_Ready,
    output logic                   Rx_Ack,
    output logic [8*NUM_BYTES-1:0] Hash_Value,
    output logic                   Hash_Valid,
    input  logic                   Hash_Ready,
    output logic                   Frame_Error,
    output logic [4:0]             Byte_Count
);

    localparam int         SYNC_STAGES = 2;
    localparam int         HW          = 8 * NUM_BYTES;
    localparam logic [4:0] FULL_COUNT  = 5'(NUM_BYTES);

    // -------------------------------------------------------------------------
    // Reset synchroniser: assertion reaches the logic immediately, release is
    // aligned to Clk so no flop sees reset removal near an active edge.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_sync_reg;
    logic [SYNC_STAGES-1:0] rst_sync_in;
    logic                   reset_int;

    assign rst_sync_in = {rst_sync_reg[SYNC_STAGES-2:0], 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_rst_sync
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    rst_sync_reg[gi] <= 1'b0;
                end else begin
                    rst_sync_reg[gi] <= rst_sync_in[gi];
                end
            end
        end
    endgenerate

    assign reset_int = rst_sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // UART handshake
    // -------------------------------------------------------------------------
    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       byte_take;
    logic       take_enable;

    // Bytes are refused only while a finished hash is waiting to be taken.
    assign take_enable = (state_reg != HOLD);

    rx_ack_ctrl u_rx_ack_ctrl (
        .Clk         (Clk),
        .Reset       (reset_int),
        .rx_ready    (Rx_Ready),
        .take_enable (take_enable),
        .rx_ack      (Rx_Ack),
        .byte_take   (byte_take)
    );

    // -------------------------------------------------------------------------
    // Frame assembly FSM
    // -------------------------------------------------------------------------
    logic [HW-1:0] hash_reg;
    logic [HW-1:0] hash_next;
    logic [4:0]    count_reg;
    logic [4:0]    count_next;
    logic          err_reg;
    logic          err_next;
    logic          rx_is_delim;

    assign rx_is_delim = is_delim(Rx_Data, DELIM);

    always_comb begin
        state_next = state_reg;
        hash_next  = hash_reg;
        count_next = count_reg;
        err_next   = 1'b0;

        case (state_reg)
            COLLECT: begin
                if (byte_take) begin
                    if (rx_is_delim) begin
                        count_next = 5'd0;
                        if (count_reg == FULL_COUNT) begin
                            state_next = HOLD;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (count_reg < FULL_COUNT) begin
                        hash_next  = {hash_reg[HW-9:0], Rx_Data};
                        count_next = count_reg + 5'd1;
                    end else begin
                        // Too many bytes: drop the rest of this frame.
                        err_next   = 1'b1;
                        count_next = 5'd0;
                        state_next = DISCARD;
                    end
                end
            end

            HOLD: begin
                if (Hash_Ready) begin
                    state_next = COLLECT;
                end
            end

            DISCARD: begin
                if (byte_take && rx_is_delim) begin
                    state_next = COLLECT;
                end
            end

            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset_int) begin
        if (!reset_int) begin
            state_reg <= COLLECT;
            hash_reg  <= '0;
            count_reg <= 5'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hash_reg  <= hash_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    assign Hash_Value  = hash_reg;
    assign Hash_Valid  = (state_reg == HOLD);
    assign Frame_Error = err_reg;
    assign Byte_Count  = count_reg;

endmodule

// File: tb/tb_hash_receiver.sv
module tb_hash_receiver;

    localparam int         NB    = 16;
    localparam logic [7:0] DELIM = 8'h2C;

    logic            Clk;
    logic            Reset;
    logic [7:0]      Rx_Data;
    logic            Rx_Ready;
    logic            Rx_Ack;
    logic [8*NB-1:0] Hash_Value;
    logic            Hash_Valid;
    logic            Hash_Ready;
    logic            Frame_Error;
    logic [4:0]      Byte_Count;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame_Error observation
    int err_cnt    = 0;
    int err_consec = 0;
    bit err_prev   = 0;

    // Reference model: frame contents so far, dropping flag, held hash
    logic [7:0]      m_q[$];
    bit              m_discard;
    bit              m_held;
    logic [8*NB-1:0] m_hash;

    hash_receiver #(.NUM_BYTES(NB), .DELIM(DELIM)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Rx_Data     (Rx_Data),
        .Rx_Ready    (Rx_Ready),
        .Rx_Ack      (Rx_Ack),
        .Hash_Value  (Hash_Value),
        .Hash_Valid  (Hash_Valid),
        .Hash_Ready  (Hash_Ready),
        .Frame_Error (Frame_Error),
        .Byte_Count  (Byte_Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(negedge Clk) begin
        if (Frame_Error === 1'b1) begin
            err_cnt++;
            if (err_prev) err_consec++;
        end
        err_prev = (Frame_Error === 1'b1);
    end

    task automatic model_reset();
        m_q.delete();
        m_discard = 0;
        m_held    = 0;
    endtask

    // Frame rules applied to one consumed byte.
    task automatic model_step(input logic [7:0] b, output bit exp_err);
        exp_err = 0;
        if (m_discard) begin
            if (b == DELIM) m_discard = 0;
        end else if (b == DELIM) begin
            if (m_q.size() == NB) begin
                m_hash = '0;
                foreach (m_q[i]) m_hash = (m_hash << 8) | (8*NB)'(m_q[i]);
                m_held = 1;
            end else begin
                exp_err = 1;
            end
            m_q.delete();
        end else if (m_q.size() < NB) begin
            m_q.push_back(b);
        end else begin
            exp_err = 1;
            m_q.delete();
            m_discard = 1;
        end
    endtask

    function automatic logic [7:0] rand_data();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == DELIM) b = 8'h2D;
        return b;
    endfunction

    // Full four-phase transfer of one byte; called and returns at a negedge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        Rx_Data  = b;
        Rx_Ready = 1'b1;
        t = 0;
        do begin @(negedge Clk); t++; end while (Rx_Ack !== 1'b1 && t < 50);
        n_checks++;
        if (Rx_Ack !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_rise: Rx_Ack=%b required 1 within 50 cycles", Rx_Ack);
        end
        Rx_Ready = 1'b0;
        t = 0;
        do begin @(negedge Clk); t++; end while (Rx_Ack !== 1'b0 && t < 50);
        n_checks++;
        if (Rx_Ack !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_fall: Rx_Ack=%b required 0 within 50 cycles", Rx_Ack);
        end
    endtask

    task automatic send_checked(input logic [7:0] b);
        int e0;
        bit exp_err;
        e0 = err_cnt;
        send_byte(b);
        model_step(b, exp_err);
        @(negedge Clk);
        $display("byte %02h count=%0d valid=%0d err=%0d", b, Byte_Count, Hash_Valid, err_cnt - e0);
        n_checks++;
        if (err_cnt - e0 !== int'(exp_err)) begin
            n_fail++;
            $display("FAIL err_pulses: got %0d required %0d", err_cnt - e0, exp_err);
        end
        n_checks++;
        if (Byte_Count !== 5'(m_q.size())) begin
            n_fail++;
            $display("FAIL byte_count: got %0d required %0d", Byte_Count, m_q.size());
        end
        n_checks++;
        if (Hash_Valid !== m_held) begin
            n_fail++;
            $display("FAIL hash_valid: got %b required %b", Hash_Valid, m_held);
        end
        if (m_held) begin
            n_checks++;
            if (Hash_Value !== m_hash) begin
                n_fail++;
                $display("FAIL hash_value: got %h required %h", Hash_Value, m_hash);
            end
        end
    endtask

    task automatic send_frame_random();
        for (int i = 0; i < NB; i++) send_checked(rand_data());
        send_checked(DELIM);
    endtask

    // Holds the hash for some cycles, then accepts it.
    task automatic do_transfer(input int delay);
        n_checks++;
        if (Hash_Valid !== 1'b1 || Hash_Value !== m_hash) begin
            n_fail++;
            $display("FAIL pre_transfer: valid=%b value=%h required 1 %h", Hash_Valid, Hash_Value, m_hash);
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge Clk);
            n_checks++;
            if (Hash_Valid !== 1'b1 || Hash_Value !== m_hash) begin
                n_fail++;
                $display("FAIL hold_stable: valid=%b value=%h required 1 %h", Hash_Valid, Hash_Value, m_hash);
            end
        end
        Hash_Ready = 1'b1;
        @(negedge Clk);
        Hash_Ready = 1'b0;
        m_held = 0;
        $display("transfer hash %h", m_hash);
        n_checks++;
        if (Hash_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_transfer_valid: got %b required 0", Hash_Valid);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if (Rx_Ack !== 1'b0 || Hash_Value !== '0 || Hash_Valid !== 1'b0 ||
            Frame_Error !== 1'b0 || Byte_Count !== 5'd0) begin
            n_fail++;
            $display("FAIL %s: ack=%b value=%h valid=%b err=%b count=%0d required all 0",
                     tag, Rx_Ack, Hash_Value, Hash_Valid, Frame_Error, Byte_Count);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; Rx_Data = 8'h00; Rx_Ready = 1'b0; Hash_Ready = 1'b0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_all_zero("reset_state");
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check_all_zero("after_release");
    endtask

    task automatic test_basic_frame();
        logic [8*NB-1:0] want;
        want = 128'h000102030405060708090A0B0C0D0E0F;
        for (int i = 0; i < NB; i++) send_checked(8'(i));
        send_checked(DELIM);
        n_checks++;
        if (Hash_Value !== want) begin
            n_fail++;
            $display("FAIL basic_hash: got %h required %h", Hash_Value, want);
        end
        do_transfer(6);
    endtask

    task automatic test_short_frame();
        int e0;
        e0 = err_cnt;
        send_checked(8'hAA);
        send_checked(8'hBB);
        send_checked(DELIM);
        n_checks++;
        if (err_cnt - e0 != 1 || Hash_Valid !== 1'b0 || Byte_Count !== 5'd0) begin
            n_fail++;
            $display("FAIL short_frame: errs=%0d valid=%b count=%0d required 1 0 0",
                     err_cnt - e0, Hash_Valid, Byte_Count);
        end
        send_checked(DELIM);  // empty frame is also an error
        send_frame_random();
        do_transfer(1);
    endtask

    task automatic test_long_frame();
        int e0;
        e0 = err_cnt;
        for (int i = 0; i < NB + 1; i++) send_checked(8'h11);
        send_checked(8'h22);
        send_checked(8'h33);
        send_checked(DELIM);
        n_checks++;
        if (err_cnt - e0 != 1 || Hash_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL long_frame: errs=%0d valid=%b required 1 0", err_cnt - e0, Hash_Valid);
        end
        send_frame_random();
        do_transfer(2);
    endtask

    task automatic test_ready_ignored();
        Hash_Ready = 1'b1;
        for (int i = 0; i < 3; i++) send_checked(rand_data());
        Hash_Ready = 1'b0;
        for (int i = 3; i < NB; i++) send_checked(rand_data());
        send_checked(DELIM);
        do_transfer(0);
    endtask

    task automatic test_hold_backpressure();
        bit exp_err;
        int t;
        send_frame_random();
        Rx_Data  = 8'h5A;
        Rx_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            n_checks++;
            if (Rx_Ack !== 1'b0 || Hash_Value !== m_hash || Byte_Count !== 5'd0) begin
                n_fail++;
                $display("FAIL hold_backpressure: ack=%b value=%h count=%0d required 0 %h 0",
                         Rx_Ack, Hash_Value, Byte_Count, m_hash);
            end
        end
        Hash_Ready = 1'b1;
        @(negedge Clk);
        Hash_Ready = 1'b0;
        m_held = 0;
        n_checks++;
        if (Rx_Ack !== 1'b0 || Hash_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL transfer_cycle: ack=%b valid=%b required 0 0", Rx_Ack, Hash_Valid);
        end
        @(negedge Clk);
        n_checks++;
        if (Rx_Ack !== 1'b1 || Byte_Count !== 5'd1) begin
            n_fail++;
            $display("FAIL first_after_transfer: ack=%b count=%0d required 1 1", Rx_Ack, Byte_Count);
        end
        Rx_Ready = 1'b0;
        t = 0;
        while (Rx_Ack !== 1'b0 && t < 50) begin @(negedge Clk); t++; end
        model_step(8'h5A, exp_err);
        $display("byte 5a taken after transfer count=%0d", Byte_Count);
        for (int i = 1; i < NB; i++) send_checked(rand_data());
        send_checked(DELIM);
        do_transfer(1);
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 8; i++) send_checked(8'hC0 + 8'(i));
        #2 Reset = 1'b0;
        #1 check_all_zero("reset_async");
        model_reset();
        repeat (2) @(negedge Clk);
        check_all_zero("reset_held");
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        send_frame_random();
        do_transfer(1);
    endtask

    task automatic test_long_ready();
        logic [4:0] c0;
        bit exp_err;
        int t;
        logic [7:0] b;
        send_checked(rand_data());
        c0 = Byte_Count;
        b = rand_data();
        Rx_Data  = b;
        Rx_Ready = 1'b1;
        repeat (5) @(negedge Clk);
        Rx_Ready = 1'b0;
        t = 0;
        while (Rx_Ack !== 1'b0 && t < 50) begin @(negedge Clk); t++; end
        model_step(b, exp_err);
        $display("byte %02h held 5 cycles count=%0d", b, Byte_Count);
        n_checks++;
        if (Byte_Count !== c0 + 5'd1) begin
            n_fail++;
            $display("FAIL long_ready: count=%0d required %0d", Byte_Count, c0 + 5'd1);
        end
        for (int i = 2; i < NB; i++) send_checked(rand_data());
        send_checked(DELIM);
        do_transfer(0);
    endtask

    task automatic test_random();
        int kind;
        int len;
        for (int f = 0; f < 20; f++) begin
            kind = $urandom_range(0, 2);
            len  = (kind == 0) ? NB : (kind == 1) ? $urandom_range(0, NB - 1)
                                                  : $urandom_range(NB + 1, NB + 4);
            for (int i = 0; i < len; i++) send_checked(rand_data());
            send_checked(DELIM);
            if (m_held) do_transfer($urandom_range(0, 4));
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_short_frame();
        test_long_frame();
        test_ready_ignored();
        test_hold_backpressure();
        test_reset_midframe();
        test_long_ready();
        test_random();
        n_checks++;
        if (err_consec != 0) begin
            n_fail++;
            $display("FAIL err_consecutive: got %0d back-to-back pulses required 0", err_consec);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hash_receiver.md
HASH_RECEIVER -- requirements
Module: hash_receiver

Interface
REQ-001 Parameter NUM_BYTES, default 16, is the number of hash bytes per frame.
REQ-002 Parameter DELIM, default 8'h2C, is the frame-terminating delimiter byte.
REQ-003 Port Clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port Reset  input  1  is the reset; it is asynchronous and active-low.
REQ-005 Port Rx_Data  input  8  is the received UART byte, valid while Rx_Ready is high.
REQ-006 Port Rx_Ready  input  1  is the UART level flag for byte available.
REQ-007 Port Rx_Ack  output  1  is the byte-consumed acknowledge to the UART.
REQ-008 Port Hash_Value  output  8*NUM_BYTES  is the assembled hash to the comparator.
REQ-009 Port Hash_Valid  output  1  is high while Hash_Value holds a complete frame.
REQ-010 Port Hash_Ready  input  1  is the comparator's acceptance of Hash_Value.
REQ-011 Port Frame_Error  output  1  is a one-cycle pulse on a malformed frame.
REQ-012 Port Byte_Count  output  5  is the number of hash bytes collected in the current frame, for the display.

Function
REQ-013 Rx handshake SHALL be four-phase: a byte is consumed only when Rx_Ready=1 and Rx_Ack=0, and Rx_Ack is registered high the next cycle and held until Rx_Ready is sampled low.
REQ-014 The FSM SHALL have exactly three states: COLLECT, HOLD, DISCARD.
REQ-015 In COLLECT, a consumed non-DELIM byte with Byte_Count<NUM_BYTES SHALL shift in as {Hash_Value[8*NUM_BYTES-9:0], Rx_Data}, so the first byte ends in the top byte, and SHALL increment Byte_Count.
REQ-016 In COLLECT, a consumed DELIM with Byte_Count==NUM_BYTES SHALL move to HOLD, assert Hash_Valid the next cycle, and clear Byte_Count.
REQ-017 In COLLECT, a consumed DELIM with Byte_Count<NUM_BYTES, including 0, SHALL pulse Frame_Error for one cycle, clear Byte_Count, and remain in COLLECT.
REQ-018 In COLLECT, a consumed non-DELIM byte with Byte_Count==NUM_BYTES SHALL pulse Frame_Error, clear Byte_Count, and move to DISCARD.
REQ-019 In DISCARD, consumed bytes SHALL be dropped; a consumed DELIM SHALL return to COLLECT with no further error pulse.
REQ-020 In HOLD, Hash_Value SHALL be stable and no new byte SHALL be consumed, which provides UART backpressure.
REQ-021 Already-asserted Rx_Ack SHALL still complete its release in HOLD.
REQ-022 In HOLD, Hash_Valid=1 with Hash_Ready=1 SHALL transfer; Hash_Valid goes low the next cycle and the state returns to COLLECT.
REQ-023 The earliest byte consumption after a transfer SHALL be the cycle after the transfer.
REQ-024 Hash_Ready while Hash_Valid=0 SHALL be ignored.
REQ-025 Frame_Error SHALL never be high for two consecutive cycles.
REQ-026 Hash_Valid SHALL never assert without exactly NUM_BYTES bytes followed by DELIM since the last DELIM, transfer, or reset.

Reset
REQ-027 Reset low SHALL immediately force: state COLLECT, Rx_Ack=0, Hash_Value=0, Hash_Valid=0, Frame_Error=0, Byte_Count=0.
REQ-028 A partial frame or held hash at reset SHALL be discarded.
REQ-029 After reset release, the first consumed byte SHALL be treated as byte 1 of a new frame.
REQ-030 Reset deassertion SHALL be synchronised to Clk before it is used by the FSM.

Structure
REQ-031 The DELIM default, the state encoding (COLLECT=2'd0, HOLD=2'd1, DISCARD=2'd2), and the NUM_BYTES default SHALL live in a shared package/include used by hash_receiver and the comparator.
REQ-032 One sub-module, rx_ack_ctrl, SHALL implement the four-phase Rx_Ready/Rx_Ack handshake and output a one-cycle byte_take strobe; all other logic is flat in hash_receiver.

Verification
REQ-033 Send bytes 00..0F then 2C, with Hash_Ready=0 -> Hash_Valid=1, Hash_Value=128'h000102030405060708090A0B0C0D0E0F, stable until Hash_Ready=1, then Hash_Valid=0 the next cycle.
REQ-034 Send AA BB 2C -> one Frame_Error pulse, Hash_Valid stays 0, Byte_Count=0; then a valid 16-byte frame -> correct hash.
REQ-035 Send 17 bytes 11 then 22 33 2C -> one Frame_Error pulse on byte 17 only, no Hash_Valid; a following valid frame is accepted.
REQ-036 Present a byte on Rx_Ready during HOLD -> Rx_Ack stays 0 until the transfer, and the byte is consumed as byte 1 of the next frame.
REQ-037 Pull Reset low after 8 bytes, then release and send a full frame -> all outputs 0 during reset, and the hash contains only the post-reset bytes.
REQ-038 Hold Rx_Ready high for 5 cycles with one byte -> exactly one consumption and Byte_Count increments by 1.
